// File: rtl/ldpc_llr_loader.sv
// Channel LLR input stage for ldpc_core: saturates and packs one frame of R*D LLRs,
// double-buffers fill vs. decode, and sequences the core reset/enable handshake.
module ldpc_llr_loader #(
  parameter int unsigned data_w = 8,
  parameter int unsigned in_w   = 10,
  parameter int unsigned R      = 24,
  parameter int unsigned D      = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [in_w-1:0]     in_llr,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic [R*D*data_w-1:0]      l_out,
  output logic                       core_rst,
  output logic                       core_en,
  input  logic [1:0]                 core_status,
  output logic                       frame_done,
  output logic [1:0]                 dec_status,
  output logic                       frame_err
);

  localparam int unsigned n     = R * D;
  localparam int unsigned cnt_w = $clog2(n);
  localparam logic signed [in_w-1:0] sat_hi = in_w'(2 ** (data_w - 1) - 1);
  localparam logic signed [in_w-1:0] sat_lo = -sat_hi;

  typedef enum logic [1:0] {
    O_EMPTY = 2'd0,
    O_RST   = 2'd1,
    O_GUARD = 2'd2,
    O_RUN   = 2'd3
  } out_state_t;

  out_state_t          ostate;
  out_state_t          ostate_nx;
  logic [cnt_w-1:0]    count;
  logic                full;
  logic [data_w-1:0]   fill_mem [n];
  logic                accept;
  logic                last_slot;
  logic                good_last;
  logic                done;
  logic                transfer;
  logic [data_w-1:0]   sat_llr;

  // Handshake, framing and transfer decisions for the current cycle.
  always_comb begin
    accept    = in_valid & in_ready;
    last_slot = (count == cnt_w'(n - 1));
    good_last = accept & last_slot & in_last;
    done      = (ostate == O_RUN) && (core_status != 2'b00);
    transfer  = full && ((ostate == O_EMPTY) || done);
  end

  // Symmetric clip so the core never sees the most negative code.
  always_comb begin
    sat_llr = in_llr[data_w-1:0];
    if (in_llr > sat_hi)
      sat_llr = sat_hi[data_w-1:0];
    else if (in_llr < sat_lo)
      sat_llr = sat_lo[data_w-1:0];
  end

  always_comb begin
    ostate_nx = ostate;
    case (ostate)
      O_EMPTY: if (transfer) ostate_nx = O_RST;
      O_RST:   ostate_nx = O_GUARD;
      O_GUARD: ostate_nx = O_RUN;
      O_RUN:   if (done) ostate_nx = transfer ? O_RST : O_EMPTY;
    endcase
  end

  // Fill buffer payload; only the full flag needs reset, contents are rewritten per frame.
  always_ff @(posedge clk) begin
    if (accept)
      fill_mem[count] <= sat_llr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count      <= '0;
      full       <= 1'b0;
      in_ready   <= 1'b0;
      l_out      <= '0;
      ostate     <= O_EMPTY;
      core_rst   <= 1'b0;
      core_en    <= 1'b0;
      frame_done <= 1'b0;
      dec_status <= 2'b00;
      frame_err  <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      frame_done <= 1'b0;
      ostate     <= ostate_nx;
      core_rst   <= (ostate_nx == O_RST);
      core_en    <= (ostate_nx == O_GUARD) || (ostate_nx == O_RUN);
      in_ready   <= !((full && !transfer) || good_last);

      if (accept) begin
        if (in_last != last_slot) begin
          count     <= '0;
          frame_err <= 1'b1;
        end else if (last_slot) begin
          count <= '0;
          full  <= 1'b1;
        end else begin
          count <= count + cnt_w'(1);
        end
      end

      // First beat of a frame lands in the most significant slot.
      if (transfer) begin
        full  <= 1'b0;
        count <= '0;
        for (int unsigned i = 0; i < n; i++)
          l_out[(n - 1 - i) * data_w +: data_w] <= fill_mem[i];
      end

      if (done) begin
        frame_done <= 1'b1;
        dec_status <= core_status;
      end
    end
  end

endmodule

// File: tb/tb_ldpc_llr_loader.sv
// Randomized self-checking bench for ldpc_llr_loader against a frame-level reference model.
module tb_ldpc_llr_loader;

  localparam int DW = 8;
  localparam int IW = 10;
  localparam int N  = 576;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [IW-1:0] in_llr = '0;
  logic                 in_last = 1'b0;
  logic                 in_ready;
  logic [N*DW-1:0]      l_out;
  logic                 core_rst;
  logic                 core_en;
  logic [1:0]           core_status = 2'b00;
  logic                 frame_done;
  logic [1:0]           dec_status;
  logic                 frame_err;

  int checks = 0;
  int errors = 0;
  int fexp [N];
  int lexp [N];
  int satv [5] = '{300, -128, -500, 127, -127};
  int satx [5] = '{127, -127, -127, 127, -127};

  ldpc_llr_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_llr(in_llr), .in_last(in_last),
    .in_ready(in_ready), .l_out(l_out), .core_rst(core_rst), .core_en(core_en),
    .core_status(core_status), .frame_done(frame_done), .dec_status(dec_status),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 127) return 127;
    if (v < -127) return -127;
    return v;
  endfunction

  function automatic int slot(input int k);
    logic signed [DW-1:0] s;
    s = l_out[(N - k) * DW - 1 -: DW];
    return int'(s);
  endfunction

  function automatic int slot_errs();
    int e = 0;
    for (int k = 0; k < N; k++)
      if (slot(k) != lexp[k]) e++;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the beat is accepted (edge + 1).
  task automatic send_beat(input int v, input bit last);
    bit acc = 1'b0;
    int waited = 0;
    in_valid = 1'b1;
    in_llr   = IW'(v);
    in_last  = last;
    while (!acc && waited < 64) begin
      acc = in_ready;
      tick();
      waited++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  // mode 0: k mod 64, mode 1: random, mode 2: saturation prefix then random.
  task automatic send_frame(input int nbeats, input int last_at, input int mode);
    int v;
    for (int k = 0; k < nbeats; k++) begin
      if (mode == 0) v = k % 64;
      else if (mode == 2 && k < 5) v = satv[k];
      else v = int'($urandom_range(0, 1023)) - 512;
      if (k < N) fexp[k] = sat(v);
      send_beat(v, k == last_at);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, int'(in_ready), 0);
    check({tag, "_core_en"}, int'(core_en), 0);
    check({tag, "_core_rst"}, int'(core_rst), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_frame_err"}, int'(frame_err), 0);
    check({tag, "_dec_status"}, int'(dec_status), 0);
    check({tag, "_l_out_zero"}, int'(l_out != '0), 0);
  endtask

  // Last beat already accepted; verify transfer into an idle core.
  task automatic check_start_from_empty(input string tag);
    check({tag, "_ready_drop"}, int'(in_ready), 0);
    check({tag, "_no_early_rst"}, int'(core_rst), 0);
    tick();
    lexp = fexp;
    check({tag, "_core_rst"}, int'(core_rst), 1);
    check({tag, "_en_low_in_rst"}, int'(core_en), 0);
    check({tag, "_ready_back"}, int'(in_ready), 1);
    check({tag, "_l_out"}, slot_errs(), 0);
    tick();
    check({tag, "_rst_pulse"}, int'(core_rst), 0);
    check({tag, "_en_guard"}, int'(core_en), 1);
    tick();
    check({tag, "_en_run"}, int'(core_en), 1);
  endtask

  initial begin
    // Reset state
    #3;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("ready_after_reset", int'(in_ready), 1);

    // Ramp frame into empty core
    send_frame(N, N - 1, 0);
    check_start_from_empty("ramp");
    check("ramp_msb_slot", slot(0), 0);
    check("ramp_slot_575", slot(N - 1), 63);
    check("ramp_slot_100", slot(100), 100 % 64);

    // Second frame fills during decode and waits for done
    send_frame(N, N - 1, 2);
    check("b2b_ready_low", int'(in_ready), 0);
    repeat (3) tick();
    check("b2b_still_waiting", int'(in_ready), 0);
    check("b2b_core_busy", int'(core_en), 1);
    check("b2b_l_out_stable", slot_errs(), 0);
    core_status = 2'b01;
    tick();
    lexp = fexp;
    check("b2b_frame_done", int'(frame_done), 1);
    check("b2b_dec_status", int'(dec_status), 1);
    check("b2b_core_rst", int'(core_rst), 1);
    check("b2b_en_drop", int'(core_en), 0);
    check("b2b_ready_back", int'(in_ready), 1);
    check("b2b_l_out", slot_errs(), 0);
    for (int i = 0; i < 5; i++) check($sformatf("sat_slot%0d", i), slot(i), satx[i]);

    // Stale status through O_RST and O_GUARD must not complete the new frame
    tick();
    check("stale_rst_no_done", int'(frame_done), 0);
    check("stale_guard_en", int'(core_en), 1);
    tick();
    check("stale_guard_no_done", int'(frame_done), 0);
    core_status = 2'b00;
    tick();
    check("run_no_done", int'(frame_done), 0);
    check("run_en", int'(core_en), 1);

    // Framing errors: early in_last, then missing in_last
    send_frame(101, 100, 1);
    check("early_last_err", int'(frame_err), 1);
    check("early_last_ready", int'(in_ready), 1);
    send_frame(N, -1, 1);
    check("missing_last_err", int'(frame_err), 1);
    check("missing_last_ready", int'(in_ready), 1);
    tick();
    check("err_is_pulse", int'(frame_err), 0);
    check("err_no_transfer", int'(core_rst), 0);
    send_frame(N, N - 1, 1);
    check("clean_no_err", int'(frame_err), 0);
    check("clean_full", int'(in_ready), 0);

    // Beats offered while not ready are ignored
    in_valid = 1'b1;
    in_llr   = IW'(99);
    in_last  = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("ignored_no_err", int'(frame_err), 0);
    core_status = 2'b10;
    tick();
    core_status = 2'b00;
    lexp = fexp;
    check("done2_frame_done", int'(frame_done), 1);
    check("done2_dec_status", int'(dec_status), 2);
    check("done2_core_rst", int'(core_rst), 1);
    check("done2_l_out", slot_errs(), 0);
    repeat (2) tick();
    check("done2_run", int'(core_en), 1);

    // Completion with nothing queued returns the core to idle
    core_status = 2'b11;
    tick();
    core_status = 2'b00;
    check("done3_frame_done", int'(frame_done), 1);
    check("done3_dec_status", int'(dec_status), 3);
    check("done3_no_rst", int'(core_rst), 0);
    check("done3_en_off", int'(core_en), 0);
    tick();
    check("idle_en_off", int'(core_en), 0);
    check("idle_l_out_held", slot_errs(), 0);

    // Reset while decoding and mid-fill
    send_frame(N, N - 1, 1);
    check_start_from_empty("pre_rst");
    send_frame(200, -1, 1);
    #2;
    rst = 1'b0;
    #1;
    check_idle_outputs("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("post_rst_ready", int'(in_ready), 1);
    send_frame(N, N - 1, 1);
    check("post_rst_no_err", int'(frame_err), 0);
    check_start_from_empty("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
